servo_bank: RTL and testbench

Parametrised multi-channel servo PWM controller; successor to the single-channel servo interface. It drives N_CH independent hobby-servo outputs from one shared 20 ms frame counter. Each channel has a commanded position, a per-frame slew limit and a frame-counted settle timer that produces a per-channel done flag. It sits between the coin-dispense sequencer, which issues position commands, and the PmodCON3 pins.

---
 rtl/servo_pkg.sv | 37 +++
 rtl/servo_channel.sv | 112 +++++++++++
 rtl/servo_bank.sv | 105 ++++++++++
 tb/tb_servo_bank.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// servo_pkg: shared definitions for the servo_bank PWM controller.
//   - default timing constants for a 100 MHz clock (20 ms frame, 1 ms minimum
//     pulse, cycles per position unit)
//   - width helpers for the pulse-width datapath and the channel index
//   - the position-to-pulse-width conversion, including the POS_MAX clamp
package servo_pkg;

  localparam int unsigned DEF_PERIOD_CYC    = 32'd2_000_000;
  localparam int unsigned DEF_MIN_PULSE_CYC = 32'd100_000;
  localparam int unsigned DEF_CYC_PER_DEG   = 32'd556;

  // ceil(log2(x)) but never below 1, so single-value fields keep one bit
  function automatic int unsigned clog2_min1(input int unsigned x);
    return (x <= 32'd2) ? 32'd1 : 32'($clog2(x));
  endfunction

  // bits needed to hold any value 0..period_cyc (pulse widths and frame counter)
  function automatic int unsigned pw_width(input int unsigned period_cyc);
    return 32'($clog2(period_cyc + 32'd1));
  endfunction

  // bits of the channel index port
  function automatic int unsigned ch_width(input int unsigned n_ch);
    return clog2_min1(n_ch);
  endfunction

  // pulse width for a commanded position; positions beyond pos_max clamp
  function automatic int unsigned pos_to_width(input int unsigned pos,
                                               input int unsigned min_pulse,
                                               input int unsigned cyc_per_deg,
                                               input int unsigned pos_max);
    int unsigned p;
    p = (pos > pos_max) ? pos_max : pos;
    return min_pulse + p * cyc_per_deg;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// servo_channel: one servo output of servo_bank.
// Holds the target width (tgt), the active width (cur), the settle counter,
// and the registered pwm/done outputs. cur only moves at frame end so a pulse
// in flight is never cut short.
// Ports:
//   clk, clr   clock and synchronous active-low reset
//   fe_i       frame-end strobe (last cycle of the frame)
//   fc_i       shared frame counter
//   en_i       output enable; 0 forces pwm low without touching state
//   load_i     accept tgt_i as the new target this cycle
//   tgt_i      commanded target width
//   pwm_o      servo pulse
//   done_o     1 = at target and held there for SETTLE_FRAMES frames
module servo_channel
  import servo_pkg::*;
#(
  parameter int unsigned PW_W          = 32'd8,
  parameter int unsigned SC_W          = 32'd4,
  parameter int unsigned HOME_W        = 32'd10,
  parameter int unsigned SLEW_CYC      = 32'd0,
  parameter int unsigned SETTLE_FRAMES = 32'd15
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            fe_i,
  input  logic [PW_W-1:0] fc_i,
  input  logic            en_i,
  input  logic            load_i,
  input  logic [PW_W-1:0] tgt_i,
  output logic            pwm_o,
  output logic            done_o
);

  localparam logic [PW_W-1:0] HOME_V   = PW_W'(HOME_W);
  localparam logic [PW_W-1:0] SLEW_V   = PW_W'(SLEW_CYC);
  localparam logic [SC_W-1:0] SETTLE_V = SC_W'(SETTLE_FRAMES);

  logic [PW_W-1:0] tgt_q, tgt_d;
  logic [PW_W-1:0] cur_q, cur_d;
  logic [SC_W-1:0] settle_q, settle_d;
  logic            pwm_q, pwm_d;
  logic            done_q, done_d;
  logic [PW_W-1:0] diff_s;
  logic [PW_W-1:0] step_s;

  // width cur would take at the next frame end: one slew step toward tgt
  always_comb begin
    diff_s = '0;
    step_s = tgt_q;
    if (tgt_q > cur_q) begin
      diff_s = tgt_q - cur_q;
    end else begin
      diff_s = cur_q - tgt_q;
    end
    if ((SLEW_CYC == 32'd0) || (diff_s <= SLEW_V)) begin
      step_s = tgt_q;
    end else if (tgt_q > cur_q) begin
      step_s = cur_q + SLEW_V;
    end else begin
      step_s = cur_q - SLEW_V;
    end
  end

  // next-state: frame-end stepping first, then the command so its settle clear wins
  always_comb begin
    cur_d    = cur_q;
    tgt_d    = tgt_q;
    settle_d = settle_q;
    if (fe_i) begin
      if (cur_q != tgt_q) begin
        cur_d    = step_s;
        settle_d = '0;
      end else if (settle_q != SETTLE_V) begin
        settle_d = settle_q + SC_W'(1'b1);
      end else begin
        settle_d = settle_q;
      end
    end else begin
      cur_d = cur_q;
    end
    // a command repeating the present target is ignored so done is not disturbed
    if (load_i && (tgt_i != tgt_q)) begin
      tgt_d    = tgt_i;
      settle_d = '0;
    end else begin
      tgt_d = tgt_q;
    end
    done_d = (cur_q == tgt_q) && (settle_q == SETTLE_V);
    pwm_d  = en_i && (fc_i < cur_q);
  end

  // channel state registers with synchronous reset to the home position
  always_ff @(posedge clk) begin
    if (!clr) begin
      tgt_q    <= HOME_V;
      cur_q    <= HOME_V;
      settle_q <= SETTLE_V;
      pwm_q    <= 1'b0;
      done_q   <= 1'b1;
    end else begin
      tgt_q    <= tgt_d;
      cur_q    <= cur_d;
      settle_q <= settle_d;
      pwm_q    <= pwm_d;
      done_q   <= done_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign done_o = done_q;

endmodule

// File: rtl/servo_bank.sv
// servo_bank: N_CH-channel hobby-servo PWM controller on one shared frame.
// Owns the frame counter, command decode and the cmd_err pulse; each channel's
// target/slew/settle logic lives in servo_channel.
// Ports:
//   clk        system clock
//   clr        synchronous active-low reset
//   cmd_valid  single-cycle command strobe (always accepted)
//   cmd_ch     target channel
//   cmd_pos    commanded position (clamped to POS_MAX)
//   en         per-channel output enable
//   pwm        servo pulse outputs
//   done       per-channel at-target-and-settled flags
//   cmd_err    one-cycle pulse for a command to a nonexistent channel
module servo_bank
  import servo_pkg::*;
#(
  parameter int unsigned N_CH          = 32'd4,
  parameter int unsigned PERIOD_CYC    = DEF_PERIOD_CYC,
  parameter int unsigned MIN_PULSE_CYC = DEF_MIN_PULSE_CYC,
  parameter int unsigned CYC_PER_DEG   = DEF_CYC_PER_DEG,
  parameter int unsigned POS_MAX       = 32'd180,
  parameter int unsigned HOME_POS      = 32'd0,
  parameter int unsigned SLEW_CYC      = 32'd0,
  parameter int unsigned SETTLE_FRAMES = 32'd15,
  localparam int unsigned CH_W         = ch_width(N_CH)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            cmd_valid,
  input  logic [CH_W-1:0] cmd_ch,
  input  logic [7:0]      cmd_pos,
  input  logic [N_CH-1:0] en,
  output logic [N_CH-1:0] pwm,
  output logic [N_CH-1:0] done,
  output logic            cmd_err
);

  localparam int unsigned     PW_W    = pw_width(PERIOD_CYC);
  localparam int unsigned     SC_W    = clog2_min1(SETTLE_FRAMES + 32'd1);
  localparam int unsigned     HOME_W  = pos_to_width(HOME_POS, MIN_PULSE_CYC, CYC_PER_DEG, POS_MAX);
  localparam logic [PW_W-1:0] FC_LAST = PW_W'(PERIOD_CYC - 32'd1);
  // one extra bit so the compare also works when N_CH is a power of two
  localparam logic [CH_W:0]   N_CH_V  = (CH_W + 1)'(N_CH);

  logic [PW_W-1:0] fc_q, fc_d;
  logic            fe_s;
  logic [PW_W-1:0] tgt_w_s;
  logic            ch_ok_s;
  logic [N_CH-1:0] load_s;
  logic            cmd_err_q, cmd_err_d;

  // frame counter wraps after the frame-end cycle
  always_comb begin
    fe_s = (fc_q == FC_LAST);
    if (fe_s) begin
      fc_d = '0;
    end else begin
      fc_d = fc_q + PW_W'(1'b1);
    end
  end

  // command decode: width conversion, channel range check, per-channel load
  always_comb begin
    tgt_w_s   = PW_W'(pos_to_width(32'(cmd_pos), MIN_PULSE_CYC, CYC_PER_DEG, POS_MAX));
    ch_ok_s   = ({1'b0, cmd_ch} < N_CH_V);
    cmd_err_d = cmd_valid && !ch_ok_s;
    for (int i = 0; i < int'(N_CH); i++) begin
      load_s[i] = cmd_valid && ch_ok_s && (cmd_ch == CH_W'(i));
    end
  end

  // frame counter and error pulse registers
  always_ff @(posedge clk) begin
    if (!clr) begin
      fc_q      <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      fc_q      <= fc_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign cmd_err = cmd_err_q;

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    servo_channel #(
      .PW_W          (PW_W),
      .SC_W          (SC_W),
      .HOME_W        (HOME_W),
      .SLEW_CYC      (SLEW_CYC),
      .SETTLE_FRAMES (SETTLE_FRAMES)
    ) u_ch (
      .clk    (clk),
      .clr    (clr),
      .fe_i   (fe_s),
      .fc_i   (fc_q),
      .en_i   (en[g]),
      .load_i (load_s[g]),
      .tgt_i  (tgt_w_s),
      .pwm_o  (pwm[g]),
      .done_o (done[g])
    );
  end

endmodule

// File: tb/tb_servo_bank.sv
// Self-checking bench for servo_bank with small frame parameters.
// A behavioural model tracks targets, widths and settle frames and predicts
// pwm/done/cmd_err every cycle; hand sequences and a vector table check the
// slew, clamp, retarget, frame-end collision and reset corner cases.
module tb_servo_bank;

  localparam int N    = 4;
  localparam int P    = 100;
  localparam int MINP = 10;
  localparam int CPD  = 1;
  localparam int PMAX = 50;
  localparam int SLEW = 5;
  localparam int SF   = 2;
  localparam int HOME = 0;

  logic       clk = 1'b0;
  logic       clr;
  logic       cmd_valid;
  logic [1:0] cmd_ch;
  logic [7:0] cmd_pos;
  logic [3:0] en;
  logic [3:0] pwm;
  logic [3:0] done;
  logic       cmd_err;

  logic       cmd_valid3;
  logic [1:0] cmd_ch3;
  logic [7:0] cmd_pos3;
  logic [2:0] en3;
  logic [2:0] pwm3;
  logic [2:0] done3;
  logic       cmd_err3;

  int checks   = 0;
  int failures = 0;

  // model state (values after the most recent edge)
  int         m_fc;
  int         m_tgt[N];
  int         m_cur[N];
  int         m_set[N];
  logic       m_rst;
  logic [3:0] e_pwm;
  logic [3:0] e_done;
  logic       e_err;
  int         acc[N];
  int         last_w[N];
  int         frames = 0;

  typedef struct packed {
    logic [1:0]      ch;
    logic [7:0]      pos;
    logic [3:0][7:0] w;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  servo_bank #(
    .N_CH(4), .PERIOD_CYC(P), .MIN_PULSE_CYC(MINP), .CYC_PER_DEG(CPD),
    .POS_MAX(PMAX), .HOME_POS(HOME), .SLEW_CYC(SLEW), .SETTLE_FRAMES(SF)
  ) u_dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .cmd_pos(cmd_pos),
    .en(en), .pwm(pwm), .done(done), .cmd_err(cmd_err)
  );

  servo_bank #(
    .N_CH(3), .PERIOD_CYC(P), .MIN_PULSE_CYC(MINP), .CYC_PER_DEG(CPD),
    .POS_MAX(PMAX), .HOME_POS(HOME), .SLEW_CYC(SLEW), .SETTLE_FRAMES(SF)
  ) u_dut3 (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid3), .cmd_ch(cmd_ch3), .cmd_pos(cmd_pos3),
    .en(en3), .pwm(pwm3), .done(done3), .cmd_err(cmd_err3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // spec-level model of one clock edge with the inputs currently driven
  task automatic model_edge();
    int w;
    int d;
    int chn;
    for (int i = 0; i < N; i++) begin
      e_done[i] = (m_cur[i] == m_tgt[i]) && (m_set[i] == SF);
      e_pwm[i]  = en[i] && (m_fc < m_cur[i]);
    end
    if (m_fc == P - 1) begin
      for (int i = 0; i < N; i++) begin
        if (m_cur[i] != m_tgt[i]) begin
          d = m_tgt[i] - m_cur[i];
          if (SLEW == 0 || (d <= SLEW && d >= -SLEW)) m_cur[i] = m_tgt[i];
          else m_cur[i] = m_cur[i] + ((d > 0) ? SLEW : -SLEW);
          m_set[i] = 0;
        end else if (m_set[i] < SF) begin
          m_set[i] = m_set[i] + 1;
        end
      end
    end
    e_err = 1'b0;
    if (cmd_valid) begin
      chn = int'(cmd_ch);
      if (chn >= N) begin
        e_err = 1'b1;
      end else begin
        w = MINP + ((int'(cmd_pos) > PMAX) ? PMAX : int'(cmd_pos)) * CPD;
        if (w != m_tgt[chn]) begin
          m_tgt[chn] = w;
          m_set[chn] = 0;
        end
      end
    end
    m_fc  = (m_fc + 1) % P;
    m_rst = !clr;
    if (!clr) begin
      m_fc   = 0;
      e_pwm  = 4'h0;
      e_done = 4'hF;
      e_err  = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_tgt[i] = MINP + HOME * CPD;
        m_cur[i] = MINP + HOME * CPD;
        m_set[i] = SF;
      end
    end
  endtask

  // one clock: model update, per-cycle comparison, per-frame width measurement
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("pwm", 32'(pwm), 32'(e_pwm));
    check("done", 32'(done), 32'(e_done));
    check("cmd_err", 32'(cmd_err), 32'(e_err));
    if (m_rst) begin
      for (int i = 0; i < N; i++) acc[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) acc[i] += int'(pwm[i]);
      if (m_fc == 0) begin
        for (int i = 0; i < N; i++) begin
          last_w[i] = acc[i];
          acc[i]    = 0;
        end
        frames++;
      end
    end
  endtask

  task automatic cmd(input logic [1:0] ch, input logic [7:0] pos);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_pos   = pos;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic run_frame();
    int f0;
    int n;
    f0 = frames;
    n  = 0;
    while (frames == f0 && n < 2 * P) begin
      cyc();
      n++;
    end
    if (frames == f0) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input logic [3:0] mask, input int budget);
    int n;
    n = 0;
    while (((done & mask) != mask) && (n < budget)) begin
      cyc();
      n++;
    end
    check("wait_done", 32'(done & mask), 32'(mask));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wexp[4];
    clr = 1'b0; cmd_valid = 1'b0; cmd_ch = 2'd0; cmd_pos = 8'd0; en = 4'hF;
    cmd_valid3 = 1'b0; cmd_ch3 = 2'd0; cmd_pos3 = 8'd0; en3 = 3'b111;
    for (int i = 0; i < N; i++) begin acc[i] = 0; last_w[i] = 0; end

    // reset state
    cyc();
    cyc();
    check("rst_done", 32'(done), 32'hF);
    check("rst_pwm", 32'(pwm), 32'h0);
    check("rst_err", 32'(cmd_err), 32'd0);
    clr = 1'b1;
    run_frame();
    run_frame();
    for (int i = 0; i < N; i++) check($sformatf("home_w%0d", i), 32'(last_w[i]), 32'd10);

    // ch1 to pos 20: done falls two cycles later, width slews 5 per frame
    cmd(2'd1, 8'd20);
    check("ch1_done_k1", 32'(done[1]), 32'd1);
    cyc();
    check("ch1_done_k2", 32'(done[1]), 32'd0);
    wexp = '{10, 15, 20, 25};
    for (int f = 0; f < 4; f++) begin
      run_frame();
      check($sformatf("ch1_slew_f%0d", f), 32'(last_w[1]), 32'(wexp[f]));
    end
    run_frame();
    check("ch1_w30_a", 32'(last_w[1]), 32'd30);
    run_frame();
    check("ch1_w30_b", 32'(last_w[1]), 32'd30);
    check("ch1_done_pre", 32'(done[1]), 32'd0);
    cyc();
    check("ch1_done_rise", 32'(done[1]), 32'd1);

    // ch0 retarget mid-slew: up toward 40, then back down to 10 from 20
    cmd(2'd0, 8'd30);
    run_frame();
    check("rt_w10", 32'(last_w[0]), 32'd10);
    run_frame();
    check("rt_w15", 32'(last_w[0]), 32'd15);
    cmd(2'd0, 8'd0);
    wexp = '{20, 15, 10, 10};
    for (int f = 0; f < 3; f++) begin
      run_frame();
      check($sformatf("rt_down_f%0d", f), 32'(last_w[0]), 32'(wexp[f]));
    end
    wait_done(4'h1, 500);
    cmd(2'd0, 8'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check($sformatf("noop_done%0d", k), 32'(done[0]), 32'd1);
    end

    // command landing on the frame-end cycle: step uses old target, settle cleared
    for (int k = 0; k < P && m_fc != P - 1; k++) cyc();
    cmd(2'd0, 8'd3);
    check("fe_w_a", 32'(last_w[0]), 32'd10);
    cyc();
    check("fe_done", 32'(done[0]), 32'd0);
    run_frame();
    check("fe_w_b", 32'(last_w[0]), 32'd10);
    run_frame();
    check("fe_w_c", 32'(last_w[0]), 32'd13);
    wait_done(4'hF, 500);

    // settled widths after single commands, including clamp and no-op cases
    vecs[0] = '{ch: 2'd2, pos: 8'd200, w: {8'd10, 8'd60, 8'd30, 8'd13}};
    vecs[1] = '{ch: 2'd0, pos: 8'd50,  w: {8'd10, 8'd60, 8'd30, 8'd60}};
    vecs[2] = '{ch: 2'd0, pos: 8'd51,  w: {8'd10, 8'd60, 8'd30, 8'd60}};
    vecs[3] = '{ch: 2'd3, pos: 8'd0,   w: {8'd10, 8'd60, 8'd30, 8'd60}};
    vecs[4] = '{ch: 2'd1, pos: 8'd255, w: {8'd10, 8'd60, 8'd60, 8'd60}};
    vecs[5] = '{ch: 2'd3, pos: 8'd37,  w: {8'd47, 8'd60, 8'd60, 8'd60}};
    vecs[6] = '{ch: 2'd2, pos: 8'd0,   w: {8'd47, 8'd10, 8'd60, 8'd60}};
    for (int v = 0; v < 7; v++) begin
      cmd(vecs[v].ch, vecs[v].pos);
      cyc();
      wait_done(4'hF, 2000);
      run_frame();
      run_frame();
      for (int i = 0; i < N; i++)
        check($sformatf("vec%0d_w%0d", v, i), 32'(last_w[i]), 32'(vecs[v].w[i]));
    end

    // out-of-range channel on a 3-channel bank
    cmd_valid3 = 1'b1; cmd_ch3 = 2'd3; cmd_pos3 = 8'd20;
    cyc();
    cmd_valid3 = 1'b0;
    check("err3_pulse", 32'(cmd_err3), 32'd1);
    check("err3_done", 32'(done3), 32'd7);
    cyc();
    check("err3_clear", 32'(cmd_err3), 32'd0);
    check("err3_done_hold", 32'(done3), 32'd7);
    cmd_valid3 = 1'b1; cmd_ch3 = 2'd2;
    cyc();
    cmd_valid3 = 1'b0;
    check("err3_valid_ch", 32'(cmd_err3), 32'd0);
    cyc();
    check("err3_done_fall", 32'(done3), 32'd3);

    // reset in the middle of a slew with ch3 disabled
    en = 4'b0111;
    cmd(2'd3, 8'd50);
    cmd(2'd2, 8'd40);
    run_frame();
    for (int k = 0; k < 37; k++) cyc();
    clr = 1'b0;
    cyc();
    clr = 1'b1;
    check("mid_rst_done", 32'(done), 32'hF);
    check("mid_rst_pwm", 32'(pwm), 32'h0);
    run_frame();
    run_frame();
    wexp = '{10, 10, 10, 0};
    for (int i = 0; i < N; i++) check($sformatf("mid_rst_w%0d", i), 32'(last_w[i]), 32'(wexp[i]));
    en = 4'hF;

    // randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      cmd_valid = ($urandom_range(0, 24) == 0);
      cmd_ch    = 2'($urandom_range(0, 3));
      cmd_pos   = 8'($urandom_range(0, 70));
      if ($urandom_range(0, 7) == 0) cmd_pos = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0) en = 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 1499) != 0);
      cyc();
    end
    cmd_valid = 1'b0;
    clr       = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
